adc_responder: RTL and testbench
================================

# adc_responder

Synthesizable SPI-style ADC responder that emulates the 12-bit single-channel serial ADC our `clk`-driven acquisition front end talks to. It oversamples the initiator's `cs`, `sclk` and `din` pins in its own faster clock domain. It shifts a latched 12-bit sample out on `dout` and decodes the 6 configuration bits sent on `din`. It sits on the emulation/loopback board and in system benches, so the IR-temp acquisition path can run without a physical converter.

## Interface
Parameters:
- `DATA_BITS`, 12, sample width shifted out per frame
- `CFG_BITS`, 6, configuration bits captured per frame
- `SYNC_STAGES`, 2, synchronizer depth on `cs`/`sclk`/`din` (≥2)

Ports:
- `clk` in 1: responder clock; must be ≥8× the `sclk` frequency
- `rst` in 1: reset, synchronous, active-high
- `cs` in 1: initiator chip select, active-low (asynchronous pin)
- `sclk` in 1: initiator serial clock; idles low (asynchronous pin)
- `din` in 1: initiator config bits (asynchronous pin)
- `sample_data` in 48: four 12-bit samples, channel n at [12n+11:12n]
- `dout` out 1: serial sample bit, MSB first
- `busy` out 1: frame in progress
- `cfg_valid` out 1: one-cycle pulse when a frame with ≥6 config bits completes
- `cfg_single`, `cfg_odd`, `cfg_unipolar`, `cfg_sleep` out 1 each: decoded bits 0, 1, 4, 5
- `cfg_addr` out 2: bits 2 (MSB) and 3
- `frame_err` out 1: one-cycle pulse on a short frame (fewer than 12 rising `sclk` edges)

## Operation
- `cs`, `sclk` and `din` each pass through `SYNC_STAGES` flops, then one edge-detect flop. Only synchronized values are used.
- States and transitions:
  - IDLE → SHIFT on the synchronized `cs` falling edge. On this edge: latch the selected 12-bit sample into the shift register, drive its MSB on `dout`, clear the edge counter `k`, set `busy=1`.
  - SHIFT → DONE on the `cs` rising edge.
  - DONE → IDLE after one cycle.
- Each synchronized `sclk` rising edge in SHIFT:
  - `k` increments, saturating at 31.
  - For k = 1..6, the synchronized `din` is stored as config bit k−1.
- Each synchronized `sclk` falling edge in SHIFT: the shift register moves left one bit, filling with 0, and `dout` takes the new MSB. Rising edge k therefore sees sample bit 12−k. Edges beyond 12 see 0.
- DONE outputs:
  - If `k` ≥ 6: the `cfg_*` outputs update from the captured bits and `cfg_valid` pulses.
  - If `k` < 12: `frame_err` pulses. Both pulses can occur in the same cycle.
  - `cfg_*` outputs hold their values between frames.
- `dout` is 0 whenever not in SHIFT.
- `sclk` edges while `cs` is high are ignored.
- If `cs` falls and rises within the synchronizer window, no frame is seen and no pulse is produced.

## Timing
- Reset values: `dout`=0, `busy`=0, `cfg_valid`=0, `frame_err`=0, all `cfg_*`=0, internal channel select=0, state IDLE.
- Reset asserted mid-frame aborts the frame immediately: no pulses, outputs return to reset values. The frame is recognized again only after a fresh `cs` fall.
- Pin-to-action latency is `SYNC_STAGES`+1 `clk` cycles (3 by default) for every edge.
- `dout` is valid no later than 3 `clk` after the `sclk` fall (or `cs` fall). The ≥8× ratio guarantees it is stable before the next `sclk` rise.
- `cfg_valid` and `frame_err` assert 4 `clk` after the `cs` pin rises and last exactly 1 cycle.
- `busy` rises 3 `clk` after the `cs` pin falls and falls in the DONE cycle.
- `sample_data` is sampled only in the `cs`-fall cycle. Later changes do not affect the current frame.

## Configuration
- `ADC_RESP_CHSEL_EN` defined:
  - The sample for frame N comes from channel `cfg_addr` decoded in the last valid frame before N (channel 0 after reset). This models the converter's one-frame channel pipeline.
  - `cfg_valid` with `cfg_sleep`=1 makes subsequent frames return 0 until a valid frame with `cfg_sleep`=0.
- `ADC_RESP_CHSEL_EN` undefined: always sends `sample_data[11:0]`; `cfg_addr` and `cfg_sleep` are reported only and do not change the data.

## Test plan
- Nominal frame: `sample_data[11:0]`=0xA5C, 13-edge frame, `din` bits 1,0,0,0,1,0 → `dout` at rising edges 1..12 = 1010_0101_1100; `cfg_valid` pulses once with `cfg_single`=1, `cfg_addr`=0, `cfg_unipolar`=1; no `frame_err`.
- Sample stability: `sample_data` changes from 0xFFF to 0x000 two `sclk` periods into the frame → the full frame still returns 0xFFF.
- Short frame: `cs` rises after 8 rising edges → `cfg_valid` and `frame_err` both pulse; after only 4 edges → only `frame_err`, and `cfg_*` keep their previous values.
- Mid-frame reset: `rst` held for 1 cycle after edge 5 → `dout`=0 and `busy`=0 on the next cycle, no pulses; the following frame is correct.
- Channel pipeline (macro on): channels = 0x111/0x222/0x333/0x444; frame with `cfg_addr`=2, then a second frame → first frame returns 0x111, second returns 0x333.
- Clock ratio: `clk`:`sclk` = 8:1 with the `sclk` phase swept over 8 offsets → zero bit errors across 64 random samples.

Source files
------------

// File: rtl/adc_responder.sv
// adc_responder
//   Emulates a 12-bit serial ADC on the SPI-style pins of the acquisition
//   front end. cs/sclk/din are oversampled in the clk domain; a latched
//   sample is shifted out MSB first on dout and the first 6 din bits of each
//   frame are decoded into configuration outputs.
//
//   Optional feature macro: ADC_RESP_CHSEL_EN
//     defined   : sample comes from channel cfg_addr of the last valid frame,
//                 and cfg_sleep=1 forces returned data to zero.
//     undefined : sample_data[11:0] is always sent; cfg_addr/cfg_sleep are
//                 reported only.
//
// Ports
//   clk, rst        responder clock (>= 8x sclk), synchronous active-high reset
//   cs, sclk, din   asynchronous initiator pins (cs active-low, sclk idles low)
//   sample_data     four samples, channel n at [12n+11:12n]
//   dout            serial sample bit, 0 outside a frame
//   busy            frame in progress
//   cfg_valid       1-cycle pulse: frame with >= 6 config bits completed
//   cfg_single, cfg_odd, cfg_addr[1:0], cfg_unipolar, cfg_sleep
//                   config bits 0, 1, {2,3}, 4, 5 of the last valid frame
//   frame_err       1-cycle pulse: frame ended with fewer than 12 sclk rises
module adc_responder #(
    parameter int DATA_BITS   = 12,
    parameter int CFG_BITS    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cs,
    input  logic                   sclk,
    input  logic                   din,
    input  logic [4*DATA_BITS-1:0] sample_data,
    output logic                   dout,
    output logic                   busy,
    output logic                   cfg_valid,
    output logic                   cfg_single,
    output logic                   cfg_odd,
    output logic [1:0]             cfg_addr,
    output logic                   cfg_unipolar,
    output logic                   cfg_sleep,
    output logic                   frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [4:0] CFG_K  = 5'(CFG_BITS);
    localparam logic [4:0] DATA_K = 5'(DATA_BITS);

    // Synchronizers plus one edge-detect flop per pin that needs edges.
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
    logic                   cs_prev_q, sclk_prev_q;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [4:0]             k_q, k_d;
    logic [CFG_BITS-1:0]    cfg_cap_q, cfg_cap_d;
    logic [CFG_BITS-1:0]    cfg_out_q, cfg_out_d;
    logic                   cfg_valid_q, cfg_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic                   cs_s, sclk_s, din_s;
    logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [DATA_BITS-1:0]   load_val;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], din};
    end

    // Sample chosen at the cs-fall cycle.
`ifdef ADC_RESP_CHSEL_EN
    always_comb begin
        load_val = '0;
        if (!cfg_sleep) begin
            for (int c = 0; c < 4; c++) begin
                if (cfg_addr == 2'(c)) begin
                    load_val = sample_data[c*DATA_BITS +: DATA_BITS];
                end
            end
        end
    end
`else
    logic unused_upper;
    assign unused_upper = ^sample_data[4*DATA_BITS-1:DATA_BITS];
    always_comb begin
        load_val = sample_data[DATA_BITS-1:0];
    end
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        k_d         = k_q;
        cfg_cap_d   = cfg_cap_q;
        cfg_out_d   = cfg_out_q;
        cfg_valid_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                // sclk activity while cs is high never reaches this state's logic.
                if (cs_fall) begin
                    state_d   = SHIFT;
                    shreg_d   = load_val;
                    k_d       = '0;
                    cfg_cap_d = '0;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    if (k_q != 5'd31) begin
                        k_d = k_q + 5'd1;
                    end
                    // Rise number k_q+1 carries config bit k_q.
                    for (int i = 0; i < CFG_BITS; i++) begin
                        if (k_q == 5'(i)) begin
                            cfg_cap_d[i] = din_s;
                        end
                    end
                end
                if (sclk_fall) begin
                    shreg_d = {shreg_q[DATA_BITS-2:0], 1'b0};
                end
                if (cs_rise) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (k_q >= CFG_K) begin
                    cfg_out_d   = cfg_cap_q;
                    cfg_valid_d = 1'b1;
                end
                if (k_q < DATA_K) begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // cs chain resets to "selected" so a pin already low during
            // reset is not mistaken for a fresh fall once reset releases.
            cs_sync_q   <= '0;
            cs_prev_q   <= 1'b0;
            sclk_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            din_sync_q  <= '0;
            state_q     <= IDLE;
            shreg_q     <= '0;
            k_q         <= '0;
            cfg_cap_q   <= '0;
            cfg_out_q   <= '0;
            cfg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            cs_prev_q   <= cs_s;
            sclk_sync_q <= sclk_sync_d;
            sclk_prev_q <= sclk_s;
            din_sync_q  <= din_sync_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            k_q         <= k_d;
            cfg_cap_q   <= cfg_cap_d;
            cfg_out_q   <= cfg_out_d;
            cfg_valid_q <= cfg_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign busy         = (state_q == SHIFT);
    assign dout         = (state_q == SHIFT) & shreg_q[DATA_BITS-1];
    assign cfg_valid    = cfg_valid_q;
    assign frame_err    = frame_err_q;
    assign cfg_single   = cfg_out_q[0];
    assign cfg_odd      = cfg_out_q[1];
    assign cfg_addr     = {cfg_out_q[2], cfg_out_q[3]};
    assign cfg_unipolar = cfg_out_q[4];
    assign cfg_sleep    = cfg_out_q[5];

endmodule

// File: tb/tb_adc_responder.sv
`timescale 1ns/1ps
module tb_adc_responder;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b1;
    logic        sclk = 1'b0;
    logic        din = 1'b0;
    logic [47:0] sample_data = '0;
    logic        dout, busy, cfg_valid, cfg_single, cfg_odd;
    logic [1:0]  cfg_addr;
    logic        cfg_unipolar, cfg_sleep, frame_err;

    always #5 clk = ~clk;

    adc_responder dut (
        .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .din(din),
        .sample_data(sample_data), .dout(dout), .busy(busy),
        .cfg_valid(cfg_valid), .cfg_single(cfg_single), .cfg_odd(cfg_odd),
        .cfg_addr(cfg_addr), .cfg_unipolar(cfg_unipolar),
        .cfg_sleep(cfg_sleep), .frame_err(frame_err)
    );

    // ---------------- monitor ----------------
    int pe_cnt = 0;
    int cv_cnt = 0, fe_cnt = 0;
    int cv_pe = 0, fe_pe = 0, busy_pe = 0;
    logic busy_prev = 1'b0;
    int t0f = 0, t0r = 0;

    always @(posedge clk) pe_cnt <= pe_cnt + 1;

    always @(negedge clk) begin
        if (cfg_valid) begin
            cv_cnt = cv_cnt + 1;
            cv_pe  = pe_cnt;
        end
        if (frame_err) begin
            fe_cnt = fe_cnt + 1;
            fe_pe  = pe_cnt;
        end
        if (busy && !busy_prev) busy_pe = pe_cnt;
        busy_prev = busy;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One frame: cs low, n_edges sclk periods (80 ns, 8 clk), cs high.
    // dout is captured at each sclk rise. Start offset is swept by phase.
    task automatic do_frame(input int phase, input int n_edges, input logic [5:0] cfg,
                            input int swap_edge, input logic [47:0] swap_val,
                            output logic [11:0] got, output int cv_n, output int fe_n);
        int cv0;
        int fe0;
        got = '0;
        @(negedge clk);
        #(0.5 + 1.25 * phase);
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        cs  = 1'b0;
        t0f = pe_cnt;
        #40;
        for (int e = 1; e <= n_edges; e++) begin
            if (e == swap_edge) sample_data = swap_val;
            din = (e <= 6) ? cfg[e-1] : 1'b0;
            #40 sclk = 1'b1;
            if (e <= 12) got[12-e] = dout;
            #40 sclk = 1'b0;
        end
        #40 cs = 1'b1;
        t0r = pe_cnt;
        din = 1'b0;
        repeat (12) @(negedge clk);
        cv_n = cv_cnt - cv0;
        fe_n = fe_cnt - fe0;
    endtask

    // ---------------- stimulus ----------------
    logic [11:0] got;
    logic [11:0] exp_v;
    int cv_n, fe_n;
    int cv0, fe0;

    initial begin
        repeat (4) @(negedge clk);
        check("reset_outputs",
              {dout, busy, cfg_valid, frame_err, cfg_single, cfg_odd, cfg_addr, cfg_unipolar, cfg_sleep},
              '0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_after_reset", {busy, dout, cfg_valid, frame_err}, '0);

        // Nominal 13-edge frame, din 1,0,0,0,1,0
        sample_data = {36'h0, 12'hA5C};
        do_frame(0, 13, 6'b010001, 0, '0, got, cv_n, fe_n);
        check("nom_data", got, 12'hA5C);
        check("nom_cfg_valid_cnt", cv_n, 1);
        check("nom_frame_err_cnt", fe_n, 0);
        check("nom_cfg", {cfg_single, cfg_odd, cfg_addr, cfg_unipolar, cfg_sleep}, 6'b100010);
        check("nom_busy_latency", busy_pe - t0f, 3);
        check("nom_cfg_valid_latency", cv_pe - t0r, 4);

        // Sample stability: data changes after two sclk periods
        sample_data = {36'h0, 12'hFFF};
        do_frame(0, 12, 6'b000000, 3, 48'h0, got, cv_n, fe_n);
        check("stab_data", got, 12'hFFF);
        check("stab_cfg_valid_cnt", cv_n, 1);
        check("stab_frame_err_cnt", fe_n, 0);

        // Short frame, 8 edges: both pulses
        sample_data = {36'h0, 12'hA5C};
        do_frame(0, 8, 6'b000011, 0, '0, got, cv_n, fe_n);
        check("short8_data", got[11:4], 8'hA5);
        check("short8_cfg_valid_cnt", cv_n, 1);
        check("short8_frame_err_cnt", fe_n, 1);
        check("short8_frame_err_latency", fe_pe - t0r, 4);
        check("short8_cfg", {cfg_single, cfg_odd, cfg_addr, cfg_unipolar, cfg_sleep}, 6'b110000);

        // Short frame, 4 edges: only frame_err, cfg held
        do_frame(0, 4, 6'b111100, 0, '0, got, cv_n, fe_n);
        check("short4_cfg_valid_cnt", cv_n, 0);
        check("short4_frame_err_cnt", fe_n, 1);
        check("short4_cfg_held", {cfg_single, cfg_odd, cfg_addr, cfg_unipolar, cfg_sleep}, 6'b110000);

        // Mid-frame reset after rising edge 5
        sample_data = {36'h0, 12'hFFF};
        @(negedge clk);
        #0.5;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        cs  = 1'b0;
        #40;
        for (int e = 1; e <= 4; e++) begin
            din = 1'b0;
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
        #40 sclk = 1'b1;
        #40;
        @(negedge clk);
        check("prerst_busy_dout", {busy, dout}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy_dout", {busy, dout}, 2'b00);
        sclk = 1'b0;
        #40 cs = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_no_cfg_valid", cv_cnt - cv0, 0);
        check("rst_no_frame_err", fe_cnt - fe0, 0);
        check("rst_idle_busy", busy, 1'b0);
        check("rst_cfg_cleared", {cfg_single, cfg_odd, cfg_addr, cfg_unipolar, cfg_sleep}, 6'b000000);

        sample_data = {36'h0, 12'h5A3};
        do_frame(0, 12, 6'b000000, 0, '0, got, cv_n, fe_n);
        check("post_rst_data", got, 12'h5A3);
        check("post_rst_pulses", {cv_n[3:0], fe_n[3:0]}, 8'h10);

        // Channel pipeline and sleep
        sample_data = {12'h444, 12'h333, 12'h222, 12'h111};
        do_frame(1, 12, 6'b000100, 0, '0, got, cv_n, fe_n);
        check("chan_a_data", got, 12'h111);
        check("chan_a_addr", cfg_addr, 2'd2);
`ifdef ADC_RESP_CHSEL_EN
        exp_v = 12'h333;
`else
        exp_v = 12'h111;
`endif
        do_frame(2, 12, 6'b100000, 0, '0, got, cv_n, fe_n);
        check("chan_b_data", got, exp_v);
        check("chan_b_sleep", cfg_sleep, 1'b1);
`ifdef ADC_RESP_CHSEL_EN
        exp_v = 12'h000;
`else
        exp_v = 12'h111;
`endif
        do_frame(3, 12, 6'b000000, 0, '0, got, cv_n, fe_n);
        check("sleep_data", got, exp_v);
        do_frame(4, 12, 6'b000000, 0, '0, got, cv_n, fe_n);
        check("wake_data", got, 12'h111);

        // 8:1 ratio, phase swept over 8 offsets, random samples
        for (int i = 0; i < 64; i++) begin
            sample_data = {16'($urandom), 32'($urandom)};
            exp_v = sample_data[11:0];
            do_frame(i % 8, 12 + $urandom_range(0, 3), 6'b000000, 0, '0, got, cv_n, fe_n);
            check($sformatf("sweep_%0d_p%0d", i, i % 8), got, exp_v);
        end
        check("sweep_pulses", {cv_n[3:0], fe_n[3:0]}, 8'h10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
